// File: rtl/ifmap_tile_feeder_pkg.sv
// Shared definitions for the ifmap feed path (also used by the skew buffer).
package ifmap_tile_feeder_pkg;

  localparam int unsigned DEF_ROWS         = 4;
  localparam int unsigned DEF_DATA_W       = 16;
  localparam int unsigned DEF_FIFO_DEPTH   = 4;
  localparam int unsigned DEF_DRAIN_CYCLES = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/ifmap_tile_feeder_sync_fifo.sv
// Synchronous FIFO with combinational head output.
// Ports: push/wr_data in, pop/rd_data out, full/empty/count status.
module ifmap_tile_feeder_sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/ifmap_tile_feeder.sv
// Buffers ifmap column vectors and emits one tile of num_vectors vectors on start,
// followed by DRAIN_CYCLES zero vectors and a one-cycle done pulse.
// Ports: in_valid/in_ready/in_data load side; start/num_vectors control;
// ifmap_out/out_valid to the skew buffer; busy/done status.
module ifmap_tile_feeder
  import ifmap_tile_feeder_pkg::*;
#(
  parameter int unsigned ROWS         = DEF_ROWS,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int unsigned DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ROWS*DATA_W-1:0] in_data,
  input  logic                   start,
  input  logic [7:0]             num_vectors,
  output logic [ROWS*DATA_W-1:0] ifmap_out,
  output logic                   out_valid,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned VEC_W   = ROWS * DATA_W;
  localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  state_t               state_q, state_d;
  logic [7:0]           len_q, len_d;
  logic [7:0]           vec_cnt_q, vec_cnt_d, vec_cnt_inc;
  logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic [VEC_W-1:0]     ifmap_out_q, ifmap_out_d;
  logic                 out_valid_q, out_valid_d;
  logic                 done_q, done_d;

  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [VEC_W-1:0]     fifo_rd_data;
  logic [CNT_W-1:0]     fifo_count;

  assign in_ready  = ~rst & ~fifo_full;
  assign fifo_push = in_valid & in_ready;

  ifmap_tile_feeder_sync_fifo #(
    .WIDTH (VEC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data (in_data),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  a_fifo_flags: assert property (@(posedge clk) disable iff (rst)
    (fifo_empty == (fifo_count == '0)) &&
    (fifo_full == (fifo_count == CNT_W'(FIFO_DEPTH))));

  // Output defaults to zero in every state; only a FEED pop loads real data.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    vec_cnt_d   = vec_cnt_q;
    drain_cnt_d = drain_cnt_q;
    ifmap_out_d = '0;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    fifo_pop    = 1'b0;
    vec_cnt_inc = vec_cnt_q + 8'd1;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d     = num_vectors;
          vec_cnt_d = '0;
          state_d   = (num_vectors != 8'd0) ? ST_FEED : ST_DONE;
        end
      end
      ST_FEED: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          ifmap_out_d = fifo_rd_data;
          out_valid_d = 1'b1;
          vec_cnt_d   = vec_cnt_inc;
          if (vec_cnt_inc == len_q) begin
            state_d     = ST_FLUSH;
            drain_cnt_d = '0;
          end
        end
      end
      ST_FLUSH: begin
        if (drain_cnt_q == DRAIN_LAST) state_d = ST_DONE;
        else                           drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      vec_cnt_q   <= '0;
      drain_cnt_q <= '0;
      ifmap_out_q <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      vec_cnt_q   <= vec_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      ifmap_out_q <= ifmap_out_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign ifmap_out = ifmap_out_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
